// File: rtl/input_controller_if.sv
// rtl/input_controller_if.sv - raw button inputs and conditioned level/strobe outputs
interface input_controller_if;
  logic jump_raw;
  logic halt_raw;
  logic jump_level;
  logic jump_press;
  logic jump_release;
  logic halt_level;
  logic halt_press;
  logic halt_release;
  logic halt_hold;

  modport master (
    output jump_raw, halt_raw,
    input  jump_level, jump_press, jump_release,
    input  halt_level, halt_press, halt_release, halt_hold
  );

  modport slave (
    input  jump_raw, halt_raw,
    output jump_level, jump_press, jump_release,
    output halt_level, halt_press, halt_release, halt_hold
  );
endinterface

// File: rtl/input_controller.sv
// rtl/input_controller.sv - synchronise and debounce jump/halt buttons into levels and strobes
// Optional long-press strobe on halt is built when INPUT_HOLD_EN is defined.
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input logic               clk,
  input logic               rst_n,
  input_controller_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is jump, 1 is halt; the two never interact.
  logic [1:0]    raw;
  logic [1:0]    s1_q, s2_q;
  logic [1:0]    level_q, level_d;
  logic [1:0]    press_q, press_d;
  logic [1:0]    release_q, release_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  assign raw = {bus.halt_raw, bus.jump_raw};

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i]   = s2_q[i];
          press_d[i]   = s2_q[i];
          release_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.jump_level   = level_q[0];
  assign bus.jump_press   = press_q[0];
  assign bus.jump_release = release_q[0];
  assign bus.halt_level   = level_q[1];
  assign bus.halt_press   = press_q[1];
  assign bus.halt_release = release_q[1];

`ifdef INPUT_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          hold_q, hold_d;

  // Saturation at HOLD_MAX keeps the strobe to one per debounced press.
  always_comb begin
    hcnt_d = '0;
    hold_d = 1'b0;
    if (level_q[1]) begin
      hcnt_d = (hcnt_q == HOLD_MAX) ? hcnt_q : hcnt_q + HW'(1);
      hold_d = (hcnt_q == HOLD_PRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      hold_q <= hold_d;
    end
  end

  assign bus.halt_hold = hold_q;
`else
  assign bus.halt_hold = 1'b0;
`endif
endmodule

// File: tb/tb_input_controller.sv
// tb/tb_input_controller.sv - scoreboard bench for input_controller with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10
module tb_input_controller;
  typedef struct {
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  // vec bit order: {halt_hold, halt_release, halt_press, halt_level, jump_release, jump_press, jump_level}
  localparam logic [6:0] STROBE_MASK = 7'b1110110;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  input_controller_if bus ();

  input_controller #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] outs();
    return {bus.halt_hold, bus.halt_release, bus.halt_press, bus.halt_level,
            bus.jump_release, bus.jump_press, bus.jump_level};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic push(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [6:0] obs;
    exp_t       e;
    obs = outs();
    if (|(obs & STROBE_MASK)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe at cycle %0d: got %b, expected no strobe", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== obs) begin
          miscompares++;
          $display("FAIL strobe_event: got cycle %0d vec %b, expected cycle %0d vec %b",
                   cyc, obs, e.cyc, e.vec);
        end
      end
    end
  end

  initial begin
    bus.jump_raw = 1'b0;
    bus.halt_raw = 1'b0;
    rst_n        = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.jump_raw = i[0];
      bus.halt_raw = ~i[0];
    end
    chk("reset_outputs", 32'(outs()), 32'h0);

    @(negedge clk);
    bus.jump_raw = 1'b0;
    bus.halt_raw = 1'b0;
    rst_n        = 1'b1;
    step(20);
    chk("idle_after_reset", 32'(outs()), 32'h0);

    // Clean jump press
    bus.jump_raw = 1'b1;
    push(cyc + 6, 7'b0000011);
    step(10);
    chk("jump_level_high", 32'(bus.jump_level), 32'h1);

    bus.jump_raw = 1'b0;
    push(cyc + 6, 7'b0000100);
    step(10);
    chk("jump_level_low", 32'(bus.jump_level), 32'h0);

    // Bounce pattern 1,1,1,0 never reaches four stable cycles
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        bus.jump_raw = (k != 3);
        step(1);
      end
    end
    step(3);
    chk("bounce_rejected", 32'(bus.jump_level), 32'h0);
    bus.jump_raw = 1'b1;
    push(cyc + 6, 7'b0000011);
    step(10);

    // Halt press, long hold, release, then a second press/hold cycle
    for (int p = 0; p < 2; p++) begin
      bus.halt_raw = 1'b1;
      push(cyc + 6, 7'b0011001);
`ifdef INPUT_HOLD_EN
      push(cyc + 16, 7'b1001001);
`endif
      step(36);
      chk("halt_level_high", 32'(bus.halt_level), 32'h1);
      bus.halt_raw = 1'b0;
      push(cyc + 6, 7'b0100001);
      step(10);
      chk("halt_level_low", 32'(bus.halt_level), 32'h0);
    end

    bus.jump_raw = 1'b0;
    push(cyc + 6, 7'b0000100);
    step(10);

    // Simultaneous presses on both channels
    bus.jump_raw = 1'b1;
    bus.halt_raw = 1'b1;
    push(cyc + 6, 7'b0011011);
`ifdef INPUT_HOLD_EN
    push(cyc + 16, 7'b1001001);
`endif
    step(20);

    // Reset with both levels high: clears silently
    rst_n = 1'b0;
    step(1);
    chk("reset_clears_levels", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    step(4);
    // Both debounce counters sit at 2 here; interrupt them with reset
    rst_n = 1'b0;
    step(1);
    chk("reset_mid_count", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    push(cyc + 6, 7'b0011011);
`ifdef INPUT_HOLD_EN
    push(cyc + 16, 7'b1001001);
`endif
    step(20);
    chk("levels_after_requalify", 32'({bus.halt_level, bus.jump_level}), 32'h3);

    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
